// File: rtl/slim_freeze_ctrl_if.sv
// slim_freeze_ctrl_if: projectile/slime geometry in, freeze status out
interface slim_freeze_ctrl_if;
  logic       tick;
  logic       ice_valid;
  logic [9:0] x_ice;
  logic [8:0] y_ice;
  logic [9:0] x_slim;
  logic [8:0] y_slim;
  logic       ice_hit;
  logic       slim_frozen;
  logic       slim_blink;
  logic [3:0] freeze_count;
  modport master (
    output tick, ice_valid, x_ice, y_ice, x_slim, y_slim,
    input  ice_hit, slim_frozen, slim_blink, freeze_count
  );
  modport slave (
    input  tick, ice_valid, x_ice, y_ice, x_slim, y_slim,
    output ice_hit, slim_frozen, slim_blink, freeze_count
  );
endinterface

// File: rtl/slim_freeze_ctrl.sv
// slim_freeze_ctrl: ice-on-slime hit detection and frozen/thaw timing
module slim_freeze_ctrl #(
  parameter int SLIM_W       = 62,
  parameter int SLIM_H       = 36,
  parameter int ICE_W        = 16,
  parameter int ICE_H        = 16,
  parameter int FREEZE_TICKS = 15,
  parameter int THAW_TICKS   = 4
) (
  input logic clk,
  input logic rst_n,
  slim_freeze_ctrl_if.slave bus
);
  localparam int FT = FREEZE_TICKS < 1 ? 1 : FREEZE_TICKS;
  localparam int TT = THAW_TICKS < 1 ? 1 : THAW_TICKS;
  localparam int CW = $clog2((FT > TT ? FT : TT) + 1);
  typedef enum logic [1:0] {ACTIVE, FROZEN, THAW} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic overlap, overlap_q, hit_evt, tk, last, blink_n;
  logic [3:0] fc_n;
  // widened sums so boxes near the screen edge never wrap
  assign overlap = bus.ice_valid &&
    ({1'b0, bus.x_ice} + 11'(ICE_W) > {1'b0, bus.x_slim}) &&
    ({1'b0, bus.x_ice} < {1'b0, bus.x_slim} + 11'(SLIM_W)) &&
    ({1'b0, bus.y_ice} + 10'(ICE_H) > {1'b0, bus.y_slim}) &&
    ({1'b0, bus.y_ice} < {1'b0, bus.y_slim} + 10'(SLIM_H));
  assign hit_evt = overlap && !overlap_q;
  assign tk      = bus.tick && state != ACTIVE;
  assign last    = cnt == CW'(1);
  always_comb begin
    state_n = hit_evt ? FROZEN : (!tk || !last) ? state : state == FROZEN ? THAW : ACTIVE;
    cnt_n   = hit_evt ? CW'(FT) : !tk ? cnt : (state == FROZEN && last) ? CW'(TT) : cnt - CW'(1);
    blink_n = hit_evt ? 1'b0 : !tk ? bus.slim_blink : state == FROZEN ? last : !last && !bus.slim_blink;
    fc_n    = bus.freeze_count + 4'(hit_evt && state != FROZEN && bus.freeze_count != 4'hf);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= ACTIVE;
      cnt              <= '0;
      overlap_q        <= 1'b0;
      bus.ice_hit      <= 1'b0;
      bus.slim_frozen  <= 1'b0;
      bus.slim_blink   <= 1'b0;
      bus.freeze_count <= 4'd0;
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      overlap_q        <= overlap;
      bus.ice_hit      <= hit_evt;
      bus.slim_frozen  <= state_n != ACTIVE;
      bus.slim_blink   <= blink_n;
      bus.freeze_count <= fc_n;
    end
  end
endmodule

// File: tb/tb_slim_freeze_ctrl.sv
// tb_slim_freeze_ctrl: scoreboard bench with a tick-budget reference model
module tb_slim_freeze_ctrl;
  localparam int FT = 15, TT = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  slim_freeze_ctrl_if bus ();
  slim_freeze_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [6:0] exp_q[$];
  int checks = 0, errors = 0;
  int tl = 0, fc = 0;
  bit prev_ov = 0;
  int cur_xi = 150, cur_yi = 210, cur_xs = 100, cur_ys = 200;
  bit cur_v = 1;
  // tl = ticks of frozen time left (freeze phase then thaw phase)
  task automatic step(input bit r, input bit t, input bit v, input int xi, input int yi, input int xs, input int ys);
    bit ov, hit, blink;
    @(negedge clk);
    rst_n = r; bus.tick = t; bus.ice_valid = v;
    bus.x_ice = 10'(xi); bus.y_ice = 9'(yi); bus.x_slim = 10'(xs); bus.y_slim = 9'(ys);
    if (!r) begin
      tl = 0; fc = 0; prev_ov = 0; hit = 0;
    end else begin
      ov = v && (xi + 16 > xs) && (xi < xs + 62) && (yi + 16 > ys) && (yi < ys + 36);
      hit = ov && !prev_ov;
      prev_ov = ov;
      if (hit) begin
        if (tl <= TT && fc < 15) fc++;
        tl = FT + TT;
      end else if (t && tl > 0) tl--;
    end
    blink = tl > 0 && tl <= TT && ((TT - tl) % 2 == 0);
    exp_q.push_back({hit, tl > 0, blink, 4'(fc)});
  endtask
  task automatic at(input bit t, input bit v, input int xi, input int yi);
    step(1, t, v, xi, yi, 100, 200);
  endtask
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        logic [6:0] e, a;
        e = exp_q.pop_front();
        a = {bus.ice_hit, bus.slim_frozen, bus.slim_blink, bus.freeze_count};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs t=%0t hit/frozen/blink/count got %b/%b/%b/%0d want %b/%b/%b/%0d",
                   $time, a[6], a[5], a[4], a[3:0], e[6], e[5], e[4], e[3:0]);
        end
      end
    end
  end
  initial begin
    bus.tick = 0; bus.ice_valid = 1; bus.x_ice = 150; bus.y_ice = 210; bus.x_slim = 100; bus.y_slim = 200;
    repeat (3) step(0, 1, 1, 150, 210, 100, 200);
    repeat (21) at(0, 1, 150, 210);
    at(0, 0, 150, 210);
    repeat (20) at(1, 0, 150, 210);
    at(0, 1, 162, 210); at(0, 1, 84, 210); at(0, 1, 163, 210); at(0, 0, 0, 0);
    at(0, 1, 161, 210);
    at(0, 0, 0, 0);
    repeat (14) begin at(1, 0, 0, 0); at(0, 0, 0, 0); end
    repeat (5) at(1, 0, 0, 0);
    repeat (3) at(0, 0, 0, 0);
    at(0, 1, 150, 210);
    repeat (17) at(1, 0, 0, 0);
    at(0, 1, 150, 210);
    repeat (10) at(1, 0, 0, 0);
    at(1, 1, 150, 210);
    repeat (14) at(1, 0, 0, 0);
    repeat (3) at(0, 0, 0, 0);
    at(1, 0, 0, 0);
    repeat (20) begin
      at(0, 1, 150, 210);
      repeat (17) at(1, 0, 0, 0);
    end
    at(0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 100, 200);
    repeat (3) at(0, 0, 0, 0);
    at(0, 1, 100, 220); at(0, 0, 0, 0);
    step(1, 1, 1, 1020, 500, 1000, 480);
    repeat (1500) begin
      if ($urandom_range(0, 39) == 0) begin
        cur_xs = $urandom_range(0, 1023); cur_ys = $urandom_range(0, 511);
      end
      if ($urandom_range(0, 3) == 0) begin
        cur_xi = cur_xs + $urandom_range(0, 100) - 30;
        cur_yi = cur_ys + $urandom_range(0, 60) - 20;
        cur_xi = cur_xi < 0 ? 0 : cur_xi > 1023 ? 1023 : cur_xi;
        cur_yi = cur_yi < 0 ? 0 : cur_yi > 511 ? 511 : cur_yi;
        cur_v = $urandom_range(0, 4) != 0;
      end
      step($urandom_range(0, 199) != 0, $urandom_range(0, 2) == 0, cur_v, cur_xi, cur_yi, cur_xs, cur_ys);
    end
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
